// File: rtl/console_mux.sv
// -----------------------------------------------------------------------------
// console_mux
//   Console aggregator for multi-core tops. Each core's UART-write stream is
//   buffered in its own FIFO; a round-robin arbiter merges the FIFOs onto one
//   tagged byte stream with a valid/ready handshake. Also registers per-core
//   LED state and produces a drained-finish flag.
//
// Optional feature (macro CONSOLE_LINE_LOCK_EN):
//   When defined, the arbiter holds its grant on a channel until that channel
//   emits 0x0A, so lines from different cores do not interleave. The lock is
//   dropped early if the locked channel runs dry while another channel has
//   data. When undefined, arbitration is pure per-byte round-robin.
//
// Parameters:
//   NUM_CORES   number of core channels (1..16)
//   FIFO_DEPTH  entries per channel FIFO (power of two, >= 2)
//   SRC_W       width of tx_src (2**SRC_W >= NUM_CORES)
//
// Ports:
//   CLK, RST_N     clock (rising edge), async active-low reset
//   uart_wr_valid  per-core byte write request
//   uart_wr_data   per-core byte, core i at [8i+7:8i]
//   uart_wr_ready  per-core accept (FIFO not full)
//   led_wr_valid   per-core LED write strobe
//   led_wr_data    per-core LED value
//   led            registered LED state
//   core_done      per-core finish pulse
//   tx_valid/tx_data/tx_src/tx_ready  merged tagged byte output
//   all_done       all cores done and every buffer drained (registered)
// -----------------------------------------------------------------------------

// Per-channel byte FIFO. Ready depends only on the registered count, so a
// full FIFO refuses a write even on a cycle where it is also being popped.
module console_mux_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_ready,
  output logic       o_nonempty
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready    = (r_count != CNT_W'(FIFO_DEPTH));
  assign o_nonempty = (r_count != '0);
  assign o_data     = r_mem[r_rd_ptr];
  assign w_push     = i_push && o_ready;
  // Pop is only honoured on data that was present before the edge.
  assign w_pop      = i_pop && o_nonempty;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module console_mux #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int SRC_W      = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_CORES-1:0]   uart_wr_valid,
  input  logic [8*NUM_CORES-1:0] uart_wr_data,
  output logic [NUM_CORES-1:0]   uart_wr_ready,
  input  logic [NUM_CORES-1:0]   led_wr_valid,
  input  logic [NUM_CORES-1:0]   led_wr_data,
  output logic [NUM_CORES-1:0]   led,
  input  logic [NUM_CORES-1:0]   core_done,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic [SRC_W-1:0]       tx_src,
  input  logic                   tx_ready,
  output logic                   all_done
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0][7:0] w_rd_data;
  logic [NUM_CORES-1:0]      w_nonempty;
  logic [NUM_CORES-1:0]      w_pop;
  logic                      w_free;
  logic                      w_grant_vld;
  logic [PTR_W-1:0]          w_grant_idx;

  logic [PTR_W-1:0]          r_rr_ptr;
  logic                      r_tx_valid;
  logic [7:0]                r_tx_data;
  logic [SRC_W-1:0]          r_tx_src;
  logic [NUM_CORES-1:0]      r_led;
  logic [NUM_CORES-1:0]      r_done;
  logic                      r_all_done;
`ifdef CONSOLE_LINE_LOCK_EN
  logic                      r_lock;
`endif

  // Output register can take a new byte when empty or being consumed.
  assign w_free = !r_tx_valid || tx_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_ch
      console_mux_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_push     (uart_wr_valid[g]),
        .i_data     (uart_wr_data[8*g +: 8]),
        .i_pop      (w_pop[g]),
        .o_data     (w_rd_data[g]),
        .o_ready    (uart_wr_ready[g]),
        .o_nonempty (w_nonempty[g])
      );
      assign w_pop[g] = w_free && w_grant_vld && (w_grant_idx == PTR_W'(g));
    end
  endgenerate

  // Round-robin search: first non-empty channel starting at rr_ptr+1.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx  = (int'(r_rr_ptr) + k) % NUM_CORES;
      cand = PTR_W'(idx);
      if (!w_grant_vld && w_nonempty[cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = cand;
      end
    end
`ifdef CONSOLE_LINE_LOCK_EN
    // rr_ptr always holds the last granted channel, so it names the lock owner.
    if (r_lock && w_nonempty[r_rr_ptr]) begin
      w_grant_vld = 1'b1;
      w_grant_idx = r_rr_ptr;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_src   <= '0;
    end else if (w_free) begin
      if (w_grant_vld) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_rd_data[w_grant_idx];
        r_tx_src   <= SRC_W'(w_grant_idx);
        r_rr_ptr   <= w_grant_idx;
      end else begin
        r_tx_valid <= 1'b0;
      end
    end
  end

`ifdef CONSOLE_LINE_LOCK_EN
  // Any granted byte other than newline (re)arms the lock on its channel;
  // with nothing to pop the lock is simply held.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lock <= 1'b0;
    end else if (w_free && w_grant_vld) begin
      r_lock <= (w_rd_data[w_grant_idx] != 8'h0A);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (led_wr_valid[i]) r_led[i] <= led_wr_data[i];
      end
    end
  end

  // Done bits are sticky; all_done looks at pre-edge state, so it trails
  // the last byte's acceptance by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_done     <= '0;
      r_all_done <= 1'b0;
    end else begin
      r_done     <= r_done | core_done;
      r_all_done <= (&r_done) && !(|w_nonempty) && !r_tx_valid;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign tx_src   = r_tx_src;
  assign led      = r_led;
  assign all_done = r_all_done;
endmodule

// File: tb/tb_console_mux.sv
module tb_console_mux;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  uart_wr_valid = '0;
  logic [15:0] uart_wr_data = '0;
  logic [1:0]  uart_wr_ready;
  logic [1:0]  led_wr_valid = '0;
  logic [1:0]  led_wr_data = '0;
  logic [1:0]  led;
  logic [1:0]  core_done = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [3:0]  tx_src;
  logic        tx_ready = 1'b0;
  logic        all_done;

  int checks = 0;
  int errors = 0;

  console_mux #(.NUM_CORES(2), .FIFO_DEPTH(8), .SRC_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .uart_wr_valid(uart_wr_valid), .uart_wr_data(uart_wr_data),
    .uart_wr_ready(uart_wr_ready),
    .led_wr_valid(led_wr_valid), .led_wr_data(led_wr_data), .led(led),
    .core_done(core_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_src(tx_src),
    .tx_ready(tx_ready), .all_done(all_done)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
    checks++; if (tx_src !== 4'h0) begin errors++; $display("FAIL rst_tx_src: got %h exp 0", tx_src); end
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL rst_led: got %b exp 00", led); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL rst_all_done: got %b exp 0", all_done); end
    checks++; if (uart_wr_ready !== 2'b11) begin errors++; $display("FAIL rst_wr_ready: got %b exp 11", uart_wr_ready); end
    @(posedge CLK); #1 RST_N = 1'b1;
    step(); step();
    checks++; if ({tx_valid, uart_wr_ready, all_done} !== 4'b0110) begin errors++; $display("FAIL idle: got v=%b rdy=%b done=%b exp v=0 rdy=11 done=0", tx_valid, uart_wr_ready, all_done); end
  endtask

  task automatic test_led();
    led_wr_valid = 2'b01; led_wr_data = 2'b01; step();
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL led_w0: got %b exp 01", led); end
    led_wr_valid = 2'b10; led_wr_data = 2'b10; step();
    checks++; if (led !== 2'b11) begin errors++; $display("FAIL led_w1: got %b exp 11", led); end
    led_wr_valid = 2'b11; led_wr_data = 2'b00; step();
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL led_w01: got %b exp 00", led); end
    led_wr_valid = 2'b00; led_wr_data = 2'b11; step();
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL led_hold: got %b exp 00", led); end
    led_wr_data = 2'b00;
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    uart_wr_valid = 2'b01; uart_wr_data = 16'h0041;
    step();
    uart_wr_valid = 2'b00;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_latency: tx_valid=%b exp 0", tx_valid); end
    step();
    checks++; if ({tx_valid, tx_data, tx_src} !== {1'b1, 8'h41, 4'h0}) begin errors++; $display("FAIL single_out: got v=%b d=%h s=%h exp v=1 d=41 s=0", tx_valid, tx_data, tx_src); end
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_drop: tx_valid=%b exp 0", tx_valid); end
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      checks++; if (uart_wr_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b exp 1", n, uart_wr_ready[1]); end
      uart_wr_valid = 2'b10; uart_wr_data = {8'(8'h80 + n), 8'h00};
      step();
    end
    // output register holds one byte, FIFO holds eight: full
    checks++; if (uart_wr_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b exp 0", uart_wr_ready[1]); end
    checks++; if ({tx_valid, tx_data, tx_src} !== {1'b1, 8'h80, 4'h1}) begin errors++; $display("FAIL bp_head: got v=%b d=%h s=%h exp v=1 d=80 s=1", tx_valid, tx_data, tx_src); end
    uart_wr_data = 16'h8900;
    step(); step();
    checks++; if ({uart_wr_ready[1], tx_data} !== {1'b0, 8'h80}) begin errors++; $display("FAIL bp_stall: got rdy=%b d=%h exp rdy=0 d=80", uart_wr_ready[1], tx_data); end
    // pop from a full FIFO while a write is offered: write must be refused
    tx_ready = 1'b1;
    step();
    uart_wr_valid = 2'b00;
    checks++; if ({uart_wr_ready[1], tx_data} !== {1'b1, 8'h81}) begin errors++; $display("FAIL bp_full_pop: got rdy=%b d=%h exp rdy=1 d=81", uart_wr_ready[1], tx_data); end
    step();
    for (int n = 2; n < 9; n++) begin
      checks++; if ({tx_valid, tx_data, tx_src} !== {1'b1, 8'(8'h80 + n), 4'h1}) begin errors++; $display("FAIL bp_drain_%0d: got v=%b d=%h s=%h exp d=%h", n, tx_valid, tx_data, tx_src, 8'(8'h80 + n)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_end: tx_valid=%b exp 0 (extra byte)", tx_valid); end
  endtask

  task automatic test_interleave();
    logic [7:0] exp_d [6];
    logic [3:0] exp_s [6];
    int got;
    exp_d = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h32, 8'h63};
    exp_s = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
    got = 0;
    tx_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 3) begin uart_wr_valid = 2'b11; uart_wr_data = {8'(8'h61 + k), 8'(8'h30 + k)}; end
      else uart_wr_valid = 2'b00;
      step();
      if (tx_valid) begin
        checks++;
        if (got >= 6) begin errors++; $display("FAIL il_extra: got d=%h s=%h exp none", tx_data, tx_src); end
        else begin
          if ({tx_data, tx_src} !== {exp_d[got], exp_s[got]}) begin errors++; $display("FAIL il_byte_%0d: got d=%h s=%h exp d=%h s=%h", got, tx_data, tx_src, exp_d[got], exp_s[got]); end
          got++;
        end
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL il_count: got %0d bytes exp 6", got); end
  endtask

  task automatic test_line_lock();
    logic [7:0] exp_d [6];
    logic [3:0] exp_s [6];
    logic [7:0] c0 [3];
    logic [7:0] c1 [3];
    int got;
    c0 = '{8'h61, 8'h62, 8'h0A};
    c1 = '{8'h78, 8'h79, 8'h0A};
`ifdef CONSOLE_LINE_LOCK_EN
    exp_d = '{8'h61, 8'h62, 8'h0A, 8'h78, 8'h79, 8'h0A};
    exp_s = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
`else
    exp_d = '{8'h61, 8'h78, 8'h62, 8'h79, 8'h0A, 8'h0A};
    exp_s = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
`endif
    got = 0;
    tx_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 3) begin uart_wr_valid = 2'b11; uart_wr_data = {c1[k], c0[k]}; end
      else uart_wr_valid = 2'b00;
      step();
      if (tx_valid) begin
        checks++;
        if (got >= 6) begin errors++; $display("FAIL ll_extra: got d=%h s=%h exp none", tx_data, tx_src); end
        else begin
          if ({tx_data, tx_src} !== {exp_d[got], exp_s[got]}) begin errors++; $display("FAIL ll_byte_%0d: got d=%h s=%h exp d=%h s=%h", got, tx_data, tx_src, exp_d[got], exp_s[got]); end
          got++;
        end
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL ll_count: got %0d bytes exp 6", got); end
  endtask

  task automatic test_done();
    tx_ready = 1'b0;
    core_done = 2'b01; step(); core_done = 2'b00;
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL done_one: got %b exp 0", all_done); end
    uart_wr_valid = 2'b10; uart_wr_data = 16'h9000; step();
    uart_wr_data = 16'h9100; step();
    uart_wr_valid = 2'b00;
    core_done = 2'b10; step(); core_done = 2'b00;
    step();
    checks++; if ({all_done, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h90}) begin errors++; $display("FAIL done_queued: got done=%b v=%b d=%h exp done=0 v=1 d=90", all_done, tx_valid, tx_data); end
    tx_ready = 1'b1;
    step();
    checks++; if ({all_done, tx_data} !== {1'b0, 8'h91}) begin errors++; $display("FAIL done_drain1: got done=%b d=%h exp done=0 d=91", all_done, tx_data); end
    step();
    checks++; if ({all_done, tx_valid} !== 2'b00) begin errors++; $display("FAIL done_drain2: got done=%b v=%b exp 0 0", all_done, tx_valid); end
    step();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_rise: got %b exp 1", all_done); end
    step(); step(); step();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b exp 1", all_done); end
  endtask

  task automatic test_reset_mid();
    led_wr_valid = 2'b11; led_wr_data = 2'b11; step();
    led_wr_valid = 2'b00;
    tx_ready = 1'b0;
    uart_wr_valid = 2'b11; uart_wr_data = 16'hA2A1; step(); step();
    uart_wr_valid = 2'b00;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: tx_valid=%b exp 1", tx_valid); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({tx_valid, all_done, led, uart_wr_ready} !== 6'b000011) begin errors++; $display("FAIL rm_async: got v=%b done=%b led=%b rdy=%b exp 0 0 00 11", tx_valid, all_done, led, uart_wr_ready); end
    @(posedge CLK); #1 RST_N = 1'b1;
    tx_ready = 1'b1;
    step(); step(); step();
    checks++; if ({tx_valid, uart_wr_ready} !== 3'b011) begin errors++; $display("FAIL rm_empty: got v=%b rdy=%b exp v=0 rdy=11", tx_valid, uart_wr_ready); end
    // round-robin pointer cleared: search starts at core 1
    uart_wr_valid = 2'b11; uart_wr_data = 16'hB2B1; step();
    uart_wr_valid = 2'b00; step();
    checks++; if ({tx_valid, tx_data, tx_src} !== {1'b1, 8'hB2, 4'h1}) begin errors++; $display("FAIL rm_rr0: got v=%b d=%h s=%h exp v=1 d=b2 s=1", tx_valid, tx_data, tx_src); end
    step();
    checks++; if ({tx_valid, tx_data, tx_src} !== {1'b1, 8'hB1, 4'h0}) begin errors++; $display("FAIL rm_rr1: got v=%b d=%h s=%h exp v=1 d=b1 s=0", tx_valid, tx_data, tx_src); end
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_end: tx_valid=%b exp 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_single();
    test_backpressure();
    test_interleave();
    test_line_lock();
    test_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
